dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the 128-bit-block data memory.
- CPU side: 32-bit word accesses.
- Memory side: 16-byte block transfers using the data memory handshake (read/write/28-bit block address/128-bit data/busywait).
- Resolves hits combinationally in one cycle; performs block write-back and refill on misses.

---
 rtl/dcache_controller.sv | 110 +++++++++++
 tb/tb_dcache_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the CPU
// load/store stage and a 128-bit-block data memory.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [31:0]                address,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       busywait,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [27:0]                mem_address,
  output logic [127:0]               mem_writedata,
  input  logic [127:0]               mem_readdata,
  input  logic                       mem_busywait
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [127:0]          lines [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [1:0]            word;
  logic                  request;
  logic                  hit;
  logic                  addr_unused;

  assign idx         = address[3+INDEX_BITS:4];
  assign addr_tag    = address[31:4+INDEX_BITS];
  assign word        = address[3:2];
  assign addr_unused = ^address[1:0];
  assign request     = read | write;
  assign hit         = valid[idx] && (tags[idx] == addr_tag);
  assign busywait    = request && !(state == IDLE && hit);
  assign readdata    = lines[idx][{word, 5'b0} +: 32];

  // Miss handling FSM; memory-side outputs are registered and depend on state only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {tags[idx], idx};
              mem_writedata <= lines[idx];
            end else begin
              state       <= REFILL;
              mem_read    <= 1'b1;
              mem_address <= address[31:4];
            end
          end else if (write && hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state         <= REFILL;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            mem_read      <= 1'b1;
            mem_address   <= address[31:4];
          end
        end
        REFILL: begin
          if (!mem_busywait) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            valid[idx]  <= 1'b1;
            dirty[idx]  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage survive reset; a reset in REFILL forces IDLE, so no partial fill lands.
  always_ff @(posedge clock) begin
    if (state == REFILL && !mem_busywait) begin
      lines[idx] <= mem_readdata;
      tags[idx]  <= addr_tag;
    end else if (state == IDLE && write && hit) begin
      lines[idx][{word, 5'b0} +: 32] <= writedata;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: 16-cycle block memory plus a
// line-level reference cache model driven by directed and random accesses.
module tb_dcache_controller;

  logic         clock;
  logic         reset;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks = 0;
  int errors = 0;

  logic [127:0] phys_mem [256];
  logic [127:0] ref_mem  [256];
  int           mem_cnt;

  bit           ref_valid [8];
  bit           ref_dirty [8];
  int           ref_tag   [8];
  logic [127:0] ref_data  [8];

  dcache_controller #(.INDEX_BITS(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [127:0] init_block(input int b);
    logic [127:0] blk;
    for (int j = 0; j < 16; j++) blk[8*j +: 8] = 8'((b * 16 + j) % 256);
    return blk;
  endfunction

  // Memory answers on the 16th cycle of each request
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt != 15);
  assign mem_readdata = phys_mem[mem_address[7:0]];

  initial begin
    for (int b = 0; b < 256; b++) phys_mem[b] = init_block(b);
    mem_cnt = 0;
    forever begin
      @(posedge clock);
      if (mem_read || mem_write) begin
        if (mem_cnt == 15) begin
          mem_cnt <= 0;
          if (mem_write) phys_mem[mem_address[7:0]] <= mem_writedata;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else begin
        mem_cnt <= 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access: predicts stall length, memory traffic and load data from the model
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    int           idx;
    int           tg;
    int           w;
    int           n;
    int           exp_stall;
    bit           miss;
    bit           wb;
    bit           exp_mr;
    bit           exp_mw;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    logic [31:0]  exp_word;

    idx     = int'(addr[6:4]);
    tg      = int'(addr >> 7);
    w       = int'(addr[3:2]);
    miss    = !(ref_valid[idx] && ref_tag[idx] == tg);
    wb      = miss && ref_valid[idx] && ref_dirty[idx];
    wb_addr = 28'(ref_tag[idx] * 8 + idx);
    wb_data = ref_data[idx];
    if (miss) begin
      if (wb) ref_mem[wb_addr[7:0]] = wb_data;
      ref_data[idx]  = ref_mem[(addr >> 4) % 256];
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx]   = tg;
    end
    exp_word  = ref_data[idx][32*w +: 32];
    exp_stall = miss ? (wb ? 33 : 17) : 0;

    @(posedge clock);
    #1;
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = wdata;
    n = 0;
    @(negedge clock);
    while (busywait && n < 60) begin
      exp_mw = wb && n >= 1 && n <= 16;
      exp_mr = miss && (wb ? (n >= 17 && n <= 32) : (n >= 1 && n <= 16));
      checkOutput("mem_write", 128'(mem_write), 128'(exp_mw));
      checkOutput("mem_read", 128'(mem_read), 128'(exp_mr));
      if (exp_mw) begin
        checkOutput("wb_address", 128'(mem_address), 128'(wb_addr));
        checkOutput("wb_data", mem_writedata, wb_data);
      end
      if (exp_mr) checkOutput("refill_address", 128'(mem_address), 128'(addr >> 4));
      n++;
      @(negedge clock);
    end
    checkOutput("stall_cycles", 128'(n), 128'(exp_stall));
    checkOutput("idle_mem_read", 128'(mem_read), 128'(0));
    checkOutput("idle_mem_write", 128'(mem_write), 128'(0));
    checkOutput("idle_mem_address", 128'(mem_address), 128'(0));
    rdata = readdata;
    if (rd && !wr) checkOutput("readdata", 128'(readdata), 128'(exp_word));
    if (wr) begin
      ref_data[idx][32*w +: 32] = wdata;
      ref_dirty[idx] = 1'b1;
    end
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    logic [31:0] rdata;
    logic [31:0] raddr;
    logic [31:0] rwdata;
    int          kind;

    for (int b = 0; b < 256; b++) ref_mem[b] = init_block(b);
    clearModel();
    reset     = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    address   = '0;
    writedata = '0;

    repeat (3) @(negedge clock);
    checkOutput("reset_busywait", 128'(busywait), 128'(0));
    checkOutput("reset_mem_read", 128'(mem_read), 128'(0));
    checkOutput("reset_mem_write", 128'(mem_write), 128'(0));
    checkOutput("reset_mem_address", 128'(mem_address), 128'(0));
    checkOutput("reset_mem_writedata", mem_writedata, 128'(0));
    reset = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(1, 0, 32'h0000_0024, 32'h0, rdata);
    checkOutput("cold_read", 128'(rdata), 128'(32'h2726_2524));
    applyStimulus(1, 0, 32'h0000_0028, 32'h0, rdata);
    checkOutput("read_hit", 128'(rdata), 128'(32'h2B2A_2928));
    applyStimulus(0, 1, 32'h0000_0020, 32'hDEAD_BEEF, rdata);
    applyStimulus(1, 0, 32'h0000_0020, 32'h0, rdata);
    checkOutput("write_hit_read", 128'(rdata), 128'(32'hDEAD_BEEF));
    applyStimulus(1, 0, 32'h0000_0120, 32'h0, rdata);
    checkOutput("evict_read", 128'(rdata), 128'(32'h2322_2120));
    applyStimulus(0, 1, 32'h0000_0040, 32'h1234_5678, rdata);
    applyStimulus(1, 0, 32'h0000_0040, 32'h0, rdata);
    checkOutput("write_alloc_read", 128'(rdata), 128'(32'h1234_5678));
    applyStimulus(1, 0, 32'h0000_0020, 32'h0, rdata);
    checkOutput("writeback_reload", 128'(rdata), 128'(32'hDEAD_BEEF));

    $display("[TB] reset during refill");
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = 32'h0000_0060;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    #1;
    checkOutput("midreset_mem_read", 128'(mem_read), 128'(0));
    checkOutput("midreset_busywait", 128'(busywait), 128'(0));
    checkOutput("midreset_mem_address", 128'(mem_address), 128'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clearModel();
    applyStimulus(1, 0, 32'h0000_0060, 32'h0, rdata);
    checkOutput("refill_after_reset", 128'(rdata), 128'(32'h6362_6160));
    applyStimulus(1, 0, 32'h0000_0044, 32'h0, rdata);
    checkOutput("dirty_dropped_by_reset", 128'(rdata), 128'(32'h4746_4544));

    $display("[TB] random accesses");
    for (int i = 0; i < 60; i++) begin
      kind   = int'($urandom_range(0, 2));
      raddr  = {21'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rwdata = $urandom;
      applyStimulus(kind != 1, kind != 0, raddr, rwdata, rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
